// File: rtl/platformniossdram_scratchpad_arbiter_pkg.sv
// Shared widths and master identifiers for the scratchpad arbiter slice.
package platformniossdram_scratchpad_arbiter_pkg;

  localparam int unsigned DefAddrW    = 14;
  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefBeW      = DefDataW / 8;
  localparam int unsigned DefMaxBurst = 4;

  typedef enum logic {
    IdNios   = 1'b0,
    IdCordic = 1'b1
  } master_id_e;

endpackage

// File: rtl/platformniossdram_rr_burst_grant.sv
// Two-requester round-robin grant with a bounded burst per owner under contention.
module platformniossdram_rr_burst_grant #(
  parameter int unsigned MaxBurst = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  localparam int unsigned CntW = $clog2(MaxBurst) + 1;

  logic            owner_q, owner_d;
  logic [CntW-1:0] run_cnt_q, run_cnt_d;
  logic            grant_id;

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11: begin
        if (run_cnt_q < CntW'(MaxBurst)) grant_o[owner_q]  = 1'b1;
        else                             grant_o[~owner_q] = 1'b1;
      end
      default: grant_o = 2'b00;
    endcase
  end

  assign grant_id = grant_o[1];

  always_comb begin
    owner_d   = owner_q;
    run_cnt_d = run_cnt_q;
    if (|grant_o) begin
      if (grant_id == owner_q) begin
        // Saturate so a long solo run cannot wrap back below MaxBurst.
        if (run_cnt_q != {CntW{1'b1}}) run_cnt_d = run_cnt_q + 1'b1;
      end else begin
        owner_d   = grant_id;
        run_cnt_d = CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q   <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      owner_q   <= owner_d;
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: rtl/platformniossdram_scratchpad_arbiter.sv
// Shares a single-port scratchpad RAM between the Nios data master and the CORDIC port.
module platformniossdram_scratchpad_arbiter
  import platformniossdram_scratchpad_arbiter_pkg::*;
#(
  parameter int unsigned AddrW    = DefAddrW,
  parameter int unsigned DataW    = DefDataW,
  parameter int unsigned BeW      = DefBeW,
  parameter int unsigned MaxBurst = DefMaxBurst
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] m0_address_i,
  input  logic [BeW-1:0]   m0_byteenable_i,
  input  logic             m0_read_i,
  input  logic             m0_write_i,
  input  logic [DataW-1:0] m0_writedata_i,
  output logic             m0_waitrequest_o,
  output logic [DataW-1:0] m0_readdata_o,
  output logic             m0_readdatavalid_o,
  input  logic [AddrW-1:0] m1_address_i,
  input  logic [BeW-1:0]   m1_byteenable_i,
  input  logic             m1_read_i,
  input  logic             m1_write_i,
  input  logic [DataW-1:0] m1_writedata_i,
  output logic             m1_waitrequest_o,
  output logic [DataW-1:0] m1_readdata_o,
  output logic             m1_readdatavalid_o,
  output logic [AddrW-1:0] ram_address_o,
  output logic [BeW-1:0]   ram_byteenable_o,
  output logic             ram_chipselect_o,
  output logic             ram_write_o,
  output logic [DataW-1:0] ram_writedata_o,
  output logic             ram_clken_o,
  input  logic [DataW-1:0] ram_readdata_i
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       rd_pend_q, rd_pend_d;
  master_id_e rd_id_q, rd_id_d;

  assign req = {m1_read_i | m1_write_i, m0_read_i | m0_write_i};

  platformniossdram_rr_burst_grant #(
    .MaxBurst (MaxBurst)
  ) u_grant (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req),
    .grant_o (grant)
  );

  assign m0_waitrequest_o = req[0] & ~grant[0];
  assign m1_waitrequest_o = req[1] & ~grant[1];

  // m1 only drives the RAM when it holds the grant; otherwise m0 fields pass through.
  always_comb begin
    ram_chipselect_o = |grant;
    if (grant[1]) begin
      ram_address_o    = m1_address_i;
      ram_byteenable_o = m1_byteenable_i;
      ram_writedata_o  = m1_writedata_i;
      ram_write_o      = m1_write_i;
    end else begin
      ram_address_o    = m0_address_i;
      ram_byteenable_o = m0_byteenable_i;
      ram_writedata_o  = m0_writedata_i;
      ram_write_o      = grant[0] & m0_write_i;
    end
  end

  assign ram_clken_o = 1'b1;

  assign rd_pend_d = ram_chipselect_o & ~ram_write_o;
  assign rd_id_d   = grant[1] ? IdCordic : IdNios;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= IdNios;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  assign m0_readdatavalid_o = rd_pend_q & (rd_id_q == IdNios);
  assign m1_readdatavalid_o = rd_pend_q & (rd_id_q == IdCordic);
  assign m0_readdata_o      = ram_readdata_i;
  assign m1_readdata_o      = ram_readdata_i;

endmodule

// File: tb/tb_platformniossdram_scratchpad_arbiter.sv
// Scoreboarded bench for the scratchpad arbiter with a behavioural 16K x 32 RAM.
module tb_platformniossdram_scratchpad_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [31:0] m0_wd, m1_wd;
  logic        m0_wait, m1_wait, m0_rdv, m1_rdv;
  logic [31:0] m0_rdata, m1_rdata;
  logic [13:0] ram_addr;
  logic [3:0]  ram_be;
  logic        ram_cs, ram_we, ram_clken;
  logic [31:0] ram_wd, ram_q;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  logic [31:0] mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr;
  logic [31:0] pl_data;

  always #5 clk = ~clk;

  platformniossdram_scratchpad_arbiter dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .m0_address_i       (m0_addr),
    .m0_byteenable_i    (m0_be),
    .m0_read_i          (m0_rd),
    .m0_write_i         (m0_wr),
    .m0_writedata_i     (m0_wd),
    .m0_waitrequest_o   (m0_wait),
    .m0_readdata_o      (m0_rdata),
    .m0_readdatavalid_o (m0_rdv),
    .m1_address_i       (m1_addr),
    .m1_byteenable_i    (m1_be),
    .m1_read_i          (m1_rd),
    .m1_write_i         (m1_wr),
    .m1_writedata_i     (m1_wd),
    .m1_waitrequest_o   (m1_wait),
    .m1_readdata_o      (m1_rdata),
    .m1_readdatavalid_o (m1_rdv),
    .ram_address_o      (ram_addr),
    .ram_byteenable_o   (ram_be),
    .ram_chipselect_o   (ram_cs),
    .ram_write_o        (ram_we),
    .ram_writedata_o    (ram_wd),
    .ram_clken_o        (ram_clken),
    .ram_readdata_i     (ram_q)
  );

  // RAM slave: write commits at the accept edge, read data one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_cs && ram_clken) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];
      end else begin
        ram_q <= mem[ram_addr];
      end
    end
  end

  // Read-return scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m0_rdv) begin
        n_checks++;
        if (q0.size() == 0) begin
          $display("FAIL m0_unexpected_rdv: got valid=1 data=%h want no return", m0_rdata);
        end else begin
          e = q0.pop_front();
          if (m0_rdata !== e.data || cyc != e.cyc + 1)
            $display("FAIL m0_return: got data=%h cyc=%0d want data=%h cyc=%0d",
                     m0_rdata, cyc, e.data, e.cyc + 1);
          else n_pass++;
        end
      end
      if (m1_rdv) begin
        n_checks++;
        if (q1.size() == 0) begin
          $display("FAIL m1_unexpected_rdv: got valid=1 data=%h want no return", m1_rdata);
        end else begin
          e = q1.pop_front();
          if (m1_rdata !== e.data || cyc != e.cyc + 1)
            $display("FAIL m1_return: got data=%h cyc=%0d want data=%h cyc=%0d",
                     m1_rdata, cyc, e.data, e.cyc + 1);
          else n_pass++;
        end
      end
      if (m0_rdv || m1_rdv) begin
        n_checks++;
        if (m0_rdv && m1_rdv) $display("FAIL both_rdv: got both valid want one");
        else n_pass++;
      end
    end
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
    m0_be = 4'hF; m1_be = 4'hF;
    m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    rst_n   = 1'b0;
    m0_rd   = 1'b1;
    m0_addr = 14'h0000;
    for (int i = 0; i < 4; i++) preload(14'(i), 32'hA0 + 32'(i));
    preload(14'h1234, 32'h1122_3344);
    for (int i = 0; i < 8; i++) preload(14'h10 + 14'(i), 32'h5000 + 32'(i));
    for (int i = 0; i < 8; i++) preload(14'h20 + 14'(i), 32'h6000 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (m0_rdv !== 1'b0) $display("FAIL reset_rdv: got %b want 0", m0_rdv);
      else n_pass++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ram_cs !== 1'b1 || m0_wait !== 1'b0)
      $display("FAIL reset_release_grant: got cs=%b wait=%b want cs=1 wait=0", ram_cs, m0_wait);
    else n_pass++;
    e.data = 32'hA0; e.cyc = cyc; q0.push_back(e);
    @(posedge clk);
    #1 m0_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_solo_reads();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      m0_rd   = 1'b1;
      m0_addr = 14'(i);
      @(negedge clk);
      n_checks++;
      if (m0_wait !== 1'b0) $display("FAIL solo_wait[%0d]: got %b want 0", i, m0_wait);
      else n_pass++;
      e.data = 32'hA0 + 32'(i); e.cyc = cyc; q0.push_back(e);
    end
    @(posedge clk);
    #1 m0_rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    logic exp_m1;
    pulse_reset();
    m0_wr = 1'b1; m0_addr = 14'h0100;
    m1_wr = 1'b1; m1_addr = 14'h0200;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_m1 = ((k / 4) % 2) == 1;
      n_checks++;
      if (m0_wait !== exp_m1 || m1_wait !== !exp_m1 || ram_we !== 1'b1 ||
          ram_addr !== (exp_m1 ? 14'h0200 : 14'h0100))
        $display("FAIL contention[%0d]: got w0=%b w1=%b we=%b addr=%h want w0=%b w1=%b",
                 k, m0_wait, m1_wait, ram_we, ram_addr, exp_m1, !exp_m1);
      else n_pass++;
    end
    @(posedge clk);
    #1 idle_inputs();
  endtask

  task automatic test_write_then_read();
    exp_t e;
    @(posedge clk);
    #1;
    m1_wr = 1'b1; m1_addr = 14'h1234; m1_wd = 32'hDEAD_BEEF; m1_be = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (m1_wait !== 1'b0 || ram_we !== 1'b1 || ram_be !== 4'b0011)
      $display("FAIL wr_accept: got wait=%b we=%b be=%b want 0 1 0011", m1_wait, ram_we, ram_be);
    else n_pass++;
    @(posedge clk);
    #1;
    m1_wr = 1'b0;
    m0_rd = 1'b1; m0_addr = 14'h1234;
    @(negedge clk);
    n_checks++;
    if (m0_wait !== 1'b0) $display("FAIL rd_after_wr_wait: got %b want 0", m0_wait);
    else n_pass++;
    e.data = 32'h1122_BEEF; e.cyc = cyc; q0.push_back(e);
    @(posedge clk);
    #1 m0_rd = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m1_rdv !== 1'b0) $display("FAIL rd_after_wr_m1_rdv: got %b want 0", m1_rdv);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_interleaved_reads();
    exp_t e;
    int   i0 = 0;
    int   i1 = 0;
    int   guard = 0;
    pulse_reset();
    m0_rd = 1'b1; m0_addr = 14'h10;
    m1_rd = 1'b1; m1_addr = 14'h20;
    while ((i0 < 8 || i1 < 8) && guard < 64) begin
      @(negedge clk);
      guard++;
      if (m0_rd && m1_rd) begin
        n_checks++;
        if ((m0_wait ^ m1_wait) !== 1'b1)
          $display("FAIL single_grant: got w0=%b w1=%b want exactly one", m0_wait, m1_wait);
        else n_pass++;
      end
      if (m0_rd && !m0_wait) begin
        e.data = 32'h5000 + 32'(i0); e.cyc = cyc; q0.push_back(e); i0++;
      end
      if (m1_rd && !m1_wait) begin
        e.data = 32'h6000 + 32'(i1); e.cyc = cyc; q1.push_back(e); i1++;
      end
      @(posedge clk);
      #1;
      m0_rd = (i0 < 8); m0_addr = 14'h10 + 14'(i0);
      m1_rd = (i1 < 8); m1_addr = 14'h20 + 14'(i1);
    end
    n_checks++;
    if (i0 != 8 || i1 != 8) $display("FAIL interleave_timeout: got %0d/%0d want 8/8", i0, i1);
    else n_pass++;
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_drops_read();
    logic exp_m1;
    @(posedge clk);
    #1;
    m1_rd = 1'b1; m1_addr = 14'h20;
    @(negedge clk);
    n_checks++;
    if (m1_wait !== 1'b0) $display("FAIL drop_accept: got wait=%b want 0", m1_wait);
    else n_pass++;
    @(posedge clk);
    #1;
    m1_rd = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m1_rdv !== 1'b0 || m0_rdv !== 1'b0)
      $display("FAIL drop_rdv: got m0=%b m1=%b want 0 0", m0_rdv, m1_rdv);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m0_wr = 1'b1; m0_addr = 14'h0300;
    m1_wr = 1'b1; m1_addr = 14'h0301;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_m1 = (k >= 4);
      n_checks++;
      if (m0_wait !== exp_m1 || m1_wait !== !exp_m1)
        $display("FAIL restart_grant[%0d]: got w0=%b w1=%b want w0=%b w1=%b",
                 k, m0_wait, m1_wait, exp_m1, !exp_m1);
      else n_pass++;
    end
    @(posedge clk);
    #1 idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_solo_reads();
    test_contention();
    test_write_then_read();
    test_interleaved_reads();
    test_reset_drops_read();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL outstanding_reads: got m0=%0d m1=%0d want 0 0", q0.size(), q1.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
